lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit sitting directly downstream of the ALU in the RV32I execute path.
- Takes the effective address computed by the ALU (op_result) plus store data and funct3, and runs a single-outstanding request/response transaction on the data bus.
- Aligns, byte-enables and sign/zero-extends data, then hands load results to writeback.
- Raises misaligned, illegal-encoding and access-fault exceptions.

Parameters:
C_TIMEOUT_CYCLES, 255, bus wait-cycle limit before access fault; used only with LSU_TIMEOUT_EN; range 1..255.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
clk_en_i  in  1  pipeline clock enable; all registers advance only when 1
ex_valid_i  in  1  memory op offered
ex_ready_o  out  1  LSU idle, can accept
ex_store_i  in  1  1=store, 0=load
ex_funct3_i  in  3  RV32I load/store funct3
ex_addr_i  in  32  effective address (ALU result)
ex_wdata_i  in  32  rs2 store data
ex_rd_i  in  5  load destination register
dbus_req_o  out  1  bus request
dbus_ack_i  in  1  request accepted
dbus_addr_o  out  32  word address, bits[1:0]=00
dbus_we_o  out  1  write
dbus_be_o  out  4  byte enables
dbus_wdata_o  out  32  lane-aligned write data
dbus_rvalid_i  in  1  read data valid
dbus_rdata_i  in  32  read data
dbus_err_i  in  1  bus error, qualified by ack (store) or rvalid (load)
wb_valid_o  out  1  one-cycle load result pulse
wb_rd_o  out  5  load destination
wb_data_o  out  32  extended load data
exc_valid_o  out  1  one-cycle exception pulse
exc_cause_o  out  4  2 illegal, 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault
exc_addr_o  out  32  faulting effective address

Behaviour:
- Reset: state IDLE; ex_ready_o=1; dbus_req_o, dbus_we_o, wb_valid_o and exc_valid_o = 0; all data/address/be outputs = 0.
- A reset mid-transaction abandons the transaction: dbus_req_o is 0 in the next cycle, and a late rvalid is ignored.
- clk_en_i=0: state, counters and outputs hold. Bus inputs are sampled only in enabled cycles, so the slave holds ack/rvalid until sampled.
- Accept: ex_valid_i & ex_ready_o in an enabled cycle N. Capture addr, wdata, funct3, store, rd. ex_ready_o=1 only in IDLE, so there is one op in flight.
- FSM:
  - IDLE -> REQ on a legal, aligned accept.
  - IDLE -> IDLE with an exception on an illegal or misaligned accept.
  - REQ -> IDLE on ack for a store.
  - REQ -> RESP on ack for a load.
  - RESP -> IDLE on rvalid.
- REQ: dbus_req_o=1 from cycle N+1. addr, we, be and wdata stay stable until ack.
- Loads: rvalid in the ack cycle is ignored, so data arrives at N+2 at the earliest. wb_valid_o pulses at N+3 and ex_ready_o=1 at N+3.
- Stores: with ack at N+1, ex_ready_o=1 at N+2. Stores never assert wb_valid_o.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other encoding gives cause 2.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0, gives cause 4 or 6. No bus request is made.
- Illegal and misaligned exceptions: exc_valid_o=1 at N+1, exc_addr_o=ex_addr_i, ex_ready_o=1 at N+1.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata = byte replicated x4.
  - SH: be=0011 or 1100 by addr[1], wdata = halfword replicated x2.
  - SW: be=1111.
- Load read enables: dbus_be_o follows the same lane rules; dbus_we_o=0.
- Load extract: shift rdata right by addr[1:0]*8. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- Bus error:
  - dbus_err_i with ack on a store gives cause 7.
  - dbus_err_i with rvalid on a load gives cause 5 and no wb_valid_o.
  - exc_valid_o pulses in the cycle after the error is sampled.
- wb_valid_o and exc_valid_o are never high together.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entering REQ or RESP and increments each enabled cycle without ack/rvalid respectively.
  - On reaching C_TIMEOUT_CYCLES, drop dbus_req_o, pulse exc_valid_o with cause 5 (load) or 7 (store) and the captured address, and return to IDLE.
  - A late rvalid in IDLE is ignored.
- Undefined: no counter; the LSU waits indefinitely and C_TIMEOUT_CYCLES is unused.

Test Plan:
- LW addr 0x1000, ack at N+1, rvalid at N+2 with rdata 0xDEADBEEF, rd=5 -> dbus_addr_o=0x1000, be=1111; wb_valid_o at N+3 with wb_data_o=0xDEADBEEF, wb_rd_o=5.
- LB addr 0x1003, rdata 0x80FF_0000 -> be=1000; wb_data_o=0xFFFFFF80. The same access as LBU -> 0x00000080.
- SH addr 0x2002, wdata 0x1234ABCD, ack delayed 3 cycles -> req held with addr 0x2000, be=1100, wdata 0xABCDABCD; no wb_valid_o; ex_ready_o=1 the cycle after ack.
- LW addr 0x1002 -> no dbus_req_o; exc_valid_o at N+1 with cause 4, exc_addr_o=0x1002. funct3=011 load -> cause 2.
- Load with rvalid and dbus_err_i=1 -> cause 5, no wb_valid_o. reset_i asserted during RESP -> IDLE next cycle; a later rvalid produces no output.
- LSU_TIMEOUT_EN, C_TIMEOUT_CYCLES=4, store with no ack -> exc cause 7 after 4 enabled wait cycles; req deasserted. With clk_en_i toggled 0/1 during the wait, only enabled cycles count.

Source files
------------

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding data-bus transaction at a time.
// Define LSU_TIMEOUT_EN to fault a bus wait after C_TIMEOUT_CYCLES cycles.
module lsu #(
    parameter int unsigned C_TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_en_i,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        ex_store_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [4:0]  ex_rd_i,
    output logic        dbus_req_o,
    input  logic        dbus_ack_i,
    output logic [31:0] dbus_addr_o,
    output logic        dbus_we_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_err_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        exc_valid_o,
    output logic [3:0]  exc_cause_o,
    output logic [31:0] exc_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_e;

    localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
    localparam logic [3:0] CAUSE_LD_MIS   = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ST_MIS   = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  rd_q, rd_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] baddr_q, baddr_d;
    logic [31:0] bwdata_q, bwdata_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        exc_valid_q, exc_valid_d;
    logic [3:0]  exc_cause_q, exc_cause_d;
    logic [31:0] exc_addr_q, exc_addr_d;

    logic        legal;
    logic        misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] rd_shift;
    logic [31:0] load_data;

`ifdef LSU_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       to_hit;

    assign cnt_inc = cnt_q + 8'd1;
    assign to_hit  = (cnt_inc == 8'(C_TIMEOUT_CYCLES));
`else
    logic [7:0] unused_timeout;

    assign unused_timeout = 8'(C_TIMEOUT_CYCLES);
`endif

    // Encoding check and lane steering for the offered op
    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        lane_be    = 4'b1111;
        lane_wdata = ex_wdata_i;
        unique case (ex_funct3_i)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !ex_store_i;
            default:                legal = 1'b0;
        endcase
        unique case (ex_funct3_i[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << ex_addr_i[1:0];
                lane_wdata = {4{ex_wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = ex_addr_i[0];
                lane_be    = ex_addr_i[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{ex_wdata_i[15:0]}};
            end
            default: misaligned = |ex_addr_i[1:0];
        endcase
    end

    assign rd_shift = dbus_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        unique case (funct3_q)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_data = {24'd0, rd_shift[7:0]};
            3'b101:  load_data = {16'd0, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        req_d       = req_q;
        we_d        = we_q;
        be_d        = be_q;
        baddr_d     = baddr_q;
        bwdata_d    = bwdata_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        exc_valid_d = 1'b0;
        exc_cause_d = exc_cause_q;
        exc_addr_d  = exc_addr_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (ex_valid_i) begin
                    store_d  = ex_store_i;
                    funct3_d = ex_funct3_i;
                    addr_d   = ex_addr_i;
                    rd_d     = ex_rd_i;
                    if (!legal || misaligned) begin
                        exc_valid_d = 1'b1;
                        exc_addr_d  = ex_addr_i;
                        if (!legal)
                            exc_cause_d = CAUSE_ILLEGAL;
                        else if (ex_store_i)
                            exc_cause_d = CAUSE_ST_MIS;
                        else
                            exc_cause_d = CAUSE_LD_MIS;
                    end else begin
                        state_d  = S_REQ;
                        req_d    = 1'b1;
                        we_d     = ex_store_i;
                        be_d     = lane_be;
                        baddr_d  = {ex_addr_i[31:2], 2'b00};
                        bwdata_d = ex_store_i ? lane_wdata : 32'd0;
`ifdef LSU_TIMEOUT_EN
                        cnt_d    = 8'd0;
`endif
                    end
                end
            end
            S_REQ: begin
                if (dbus_ack_i) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (store_q) begin
                        state_d = S_IDLE;
                        if (dbus_err_i) begin
                            exc_valid_d = 1'b1;
                            exc_cause_d = CAUSE_ST_FAULT;
                            exc_addr_d  = addr_q;
                        end
                    end else begin
                        state_d = S_RESP;
`ifdef LSU_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end
                end else begin
`ifdef LSU_TIMEOUT_EN
                    cnt_d = cnt_inc;
                    if (to_hit) begin
                        state_d     = S_IDLE;
                        req_d       = 1'b0;
                        we_d        = 1'b0;
                        exc_valid_d = 1'b1;
                        exc_addr_d  = addr_q;
                        exc_cause_d = store_q ? CAUSE_ST_FAULT
                                              : CAUSE_LD_FAULT;
                    end
`endif
                end
            end
            S_RESP: begin
                if (dbus_rvalid_i) begin
                    state_d = S_IDLE;
                    if (dbus_err_i) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = CAUSE_LD_FAULT;
                        exc_addr_d  = addr_q;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_data;
                    end
                end else begin
`ifdef LSU_TIMEOUT_EN
                    cnt_d = cnt_inc;
                    if (to_hit) begin
                        state_d     = S_IDLE;
                        exc_valid_d = 1'b1;
                        exc_cause_d = CAUSE_LD_FAULT;
                        exc_addr_d  = addr_q;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            rd_q        <= 5'd0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= 4'd0;
            baddr_q     <= 32'd0;
            bwdata_q    <= 32'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= 4'd0;
            exc_addr_q  <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
        end else if (clk_en_i) begin
            state_q     <= state_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            req_q       <= req_d;
            we_q        <= we_d;
            be_q        <= be_d;
            baddr_q     <= baddr_d;
            bwdata_q    <= bwdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_addr_q  <= exc_addr_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign ex_ready_o   = (state_q == S_IDLE);
    assign dbus_req_o   = req_q;
    assign dbus_addr_o  = baddr_q;
    assign dbus_we_o    = we_q;
    assign dbus_be_o    = be_q;
    assign dbus_wdata_o = bwdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign exc_valid_o  = exc_valid_q;
    assign exc_cause_o  = exc_cause_q;
    assign exc_addr_o   = exc_addr_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed and randomized ops against a byte-level model.
// Timeout scenario compiles only when LSU_TIMEOUT_EN is defined.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset_i, clk_en_i;
    logic        ex_valid_i, ex_ready_o, ex_store_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_addr_i, ex_wdata_i;
    logic [4:0]  ex_rd_i;
    logic        dbus_req_o, dbus_ack_i, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
    logic [3:0]  dbus_be_o;
    logic        dbus_rvalid_i, dbus_err_i;
    logic        wb_valid_o, exc_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o, exc_addr_o;
    logic [3:0]  exc_cause_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu #(.C_TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_store_i(ex_store_i), .ex_funct3_i(ex_funct3_i),
        .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_rd_i(ex_rd_i),
        .dbus_req_o(dbus_req_o), .dbus_ack_i(dbus_ack_i),
        .dbus_addr_o(dbus_addr_o), .dbus_we_o(dbus_we_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
        .dbus_err_i(dbus_err_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o),
        .exc_addr_o(exc_addr_o)
    );

    // Reference model: byte-count arithmetic from the ISA rules
    function automatic logic [3:0] m_cause(input bit st, input logic [2:0] f3,
                                           input logic [31:0] a);
        int sz;
        if (f3 == 3'd3 || f3 > 3'd5 || (st && f3 > 3'd2)) return 4'd2;
        sz = 1 << f3[1:0];
        if (int'(a[1:0]) % sz != 0) return st ? 4'd6 : 4'd4;
        return 4'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = 1 << f3[1:0];
        return 4'(((1 << sz) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int sz;
        sz = 1 << f3[1:0];
        r = 32'd0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdat);
        longint v, mask;
        int nb;
        nb = 1 << f3[1:0];
        v = longint'(rdat) >> (8 * int'(a[1:0]));
        mask = (longint'(1) << (8 * nb)) - 1;
        v = v & mask;
        if (!f3[2] && nb < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
        return 32'(v);
    endfunction

    // Observations of the last run_op (cycle numbers relative to accept)
    bit          o_req_seen, o_unstable, o_both, o_req_after, o_extra;
    logic [31:0] o_addr, o_wdata, o_wb_data, o_exc_addr;
    logic [3:0]  o_be, o_cause;
    logic        o_we;
    logic [4:0]  o_wb_rd;
    int          o_wb_t, o_exc_t, o_ready_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        dbus_ack_i = 0; dbus_rvalid_i = 0; dbus_err_i = 0; dbus_rdata_i = 0;
    endtask

    // Drives one op and plays the bus slave; records what it observes
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input int ack_dly, input int rv_dly,
                          input logic [31:0] rdat, input bit err, input bit junk);
        int t, nreq, ack_t;
        bit acked, rvd;
        o_req_seen = 0; o_unstable = 0; o_both = 0; o_req_after = 0;
        o_wb_t = -1; o_exc_t = -1; o_ready_t = -1;
        o_wb_data = 0; o_wb_rd = 0; o_cause = 0; o_exc_addr = 0;
        o_addr = 0; o_be = 0; o_we = 0; o_wdata = 0;
        ex_valid_i = 1; ex_store_i = st; ex_funct3_i = f3;
        ex_addr_i = a; ex_wdata_i = wd; ex_rd_i = rd;
        step();
        ex_valid_i = 0; ex_store_i = 1'($urandom); ex_funct3_i = 3'($urandom);
        ex_addr_i = $urandom; ex_wdata_i = $urandom; ex_rd_i = 5'($urandom);
        nreq = 0; ack_t = -1; acked = 0; rvd = 0; t = 1;
        while (t <= 40 && o_ready_t < 0) begin
            if (wb_valid_o && o_wb_t < 0) begin
                o_wb_t = t; o_wb_data = wb_data_o; o_wb_rd = wb_rd_o;
            end
            if (exc_valid_o && o_exc_t < 0) begin
                o_exc_t = t; o_cause = exc_cause_o; o_exc_addr = exc_addr_o;
            end
            if (wb_valid_o && exc_valid_o) o_both = 1;
            if (ex_ready_o) begin
                o_ready_t = t; o_req_after = dbus_req_o;
            end
            bus_idle();
            dbus_rdata_i = $urandom;
            if (o_ready_t < 0) begin
                if (!acked && dbus_req_o) begin
                    if (!o_req_seen) begin
                        o_addr = dbus_addr_o; o_be = dbus_be_o;
                        o_we = dbus_we_o; o_wdata = dbus_wdata_o;
                    end else if (o_addr !== dbus_addr_o || o_be !== dbus_be_o ||
                                 o_we !== dbus_we_o || o_wdata !== dbus_wdata_o)
                        o_unstable = 1;
                    o_req_seen = 1;
                    if (nreq == ack_dly) begin
                        dbus_ack_i = 1; dbus_err_i = st & err;
                        acked = 1; ack_t = t;
                        if (junk && !st) begin
                            dbus_rvalid_i = 1; dbus_rdata_i = ~rdat;
                        end
                    end
                    nreq++;
                end else if (acked && !st && !rvd && t == ack_t + 1 + rv_dly) begin
                    dbus_rvalid_i = 1; dbus_rdata_i = rdat; dbus_err_i = err;
                    rvd = 1;
                end
            end
            step();
            t++;
        end
        bus_idle();
        o_extra = wb_valid_o | exc_valid_o;
    endtask

    task automatic test_reset();
        reset_i = 1; clk_en_i = 1; ex_valid_i = 0; ex_store_i = 0;
        ex_funct3_i = 0; ex_addr_i = 0; ex_wdata_i = 0; ex_rd_i = 0;
        bus_idle();
        step(); step();
        reset_i = 0;
        checks++;
        if (ex_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b exp=1", ex_ready_o);
        end
        checks++;
        if ({dbus_req_o, dbus_we_o, wb_valid_o, exc_valid_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0000",
                     {dbus_req_o, dbus_we_o, wb_valid_o, exc_valid_o});
        end
        checks++;
        if ({dbus_addr_o, dbus_wdata_o, dbus_be_o} !== 68'd0) begin
            errors++; $display("FAIL reset_bus got=%h/%h/%h exp=0",
                               dbus_addr_o, dbus_wdata_o, dbus_be_o);
        end
        checks++;
        if ({wb_data_o, wb_rd_o, exc_addr_o, exc_cause_o} !== 73'd0) begin
            errors++; $display("FAIL reset_out got=%h/%h/%h/%h exp=0",
                               wb_data_o, wb_rd_o, exc_addr_o, exc_cause_o);
        end
    endtask

    task automatic test_directed();
        run_op(0, 3'b010, 32'h1000, 0, 5'd5, 0, 0, 32'hDEADBEEF, 0, 0);
        checks++;
        if ({o_addr, o_be, o_we} !== {32'h1000, 4'b1111, 1'b0}) begin
            errors++; $display("FAIL lw_bus got=%h/%b/%b exp=00001000/1111/0",
                               o_addr, o_be, o_we);
        end
        checks++;
        if (o_wb_t !== 3 || o_wb_data !== 32'hDEADBEEF || o_wb_rd !== 5'd5) begin
            errors++; $display("FAIL lw_wb got=t%0d %h rd%0d exp=t3 deadbeef rd5",
                               o_wb_t, o_wb_data, o_wb_rd);
        end
        run_op(0, 3'b000, 32'h1003, 0, 5'd9, 0, 1, 32'h80FF_0000, 0, 1);
        checks++;
        if (o_be !== 4'b1000 || o_wb_data !== 32'hFFFFFF80) begin
            errors++; $display("FAIL lb got=be%b %h exp=be1000 ffffff80",
                               o_be, o_wb_data);
        end
        run_op(0, 3'b100, 32'h1003, 0, 5'd9, 1, 0, 32'h80FF_0000, 0, 0);
        checks++;
        if (o_wb_data !== 32'h00000080) begin
            errors++; $display("FAIL lbu got=%h exp=00000080", o_wb_data);
        end
        run_op(1, 3'b001, 32'h2002, 32'h1234ABCD, 5'd1, 3, 0, 0, 0, 0);
        checks++;
        if ({o_addr, o_be, o_wdata, o_we} !== {32'h2000, 4'b1100, 32'hABCDABCD, 1'b1}
            || o_unstable) begin
            errors++; $display("FAIL sh_bus got=%h/%b/%h/%b unst=%0d exp=2000/1100/abcdabcd/1/0",
                               o_addr, o_be, o_wdata, o_we, o_unstable);
        end
        checks++;
        if (o_ready_t !== 5 || o_wb_t !== -1 || o_req_after !== 1'b0) begin
            errors++; $display("FAIL sh_done got=rdy%0d wb%0d req%b exp=rdy5 wb-1 req0",
                               o_ready_t, o_wb_t, o_req_after);
        end
        run_op(0, 3'b010, 32'h1002, 0, 5'd3, 0, 0, 0, 0, 0);
        checks++;
        if (o_exc_t !== 1 || o_cause !== 4'd4 || o_exc_addr !== 32'h1002 ||
            o_ready_t !== 1 || o_req_after !== 1'b0) begin
            errors++; $display("FAIL lw_mis got=t%0d c%0d %h rdy%0d req%b exp=t1 c4 1002 rdy1 req0",
                               o_exc_t, o_cause, o_exc_addr, o_ready_t, o_req_after);
        end
        run_op(0, 3'b011, 32'h1000, 0, 5'd3, 0, 0, 0, 0, 0);
        checks++;
        if (o_exc_t !== 1 || o_cause !== 4'd2 || o_req_after !== 1'b0) begin
            errors++; $display("FAIL illegal got=t%0d c%0d req%b exp=t1 c2 req0",
                               o_exc_t, o_cause, o_req_after);
        end
        run_op(0, 3'b010, 32'h3000, 0, 5'd4, 0, 2, 32'h55, 1, 0);
        checks++;
        if (o_exc_t !== 5 || o_cause !== 4'd5 || o_exc_addr !== 32'h3000 ||
            o_wb_t !== -1) begin
            errors++; $display("FAIL ld_err got=t%0d c%0d %h wb%0d exp=t5 c5 3000 wb-1",
                               o_exc_t, o_cause, o_exc_addr, o_wb_t);
        end
    endtask

    task automatic test_reset_mid();
        ex_valid_i = 1; ex_store_i = 0; ex_funct3_i = 3'b010;
        ex_addr_i = 32'h4444; ex_rd_i = 5'd8;
        step();
        ex_valid_i = 0; dbus_ack_i = 1;
        step();
        dbus_ack_i = 0; reset_i = 1;
        step();
        reset_i = 0;
        checks++;
        if (dbus_req_o !== 1'b0 || ex_ready_o !== 1'b1) begin
            errors++; $display("FAIL rst_mid got=req%b rdy%b exp=req0 rdy1",
                               dbus_req_o, ex_ready_o);
        end
        dbus_rvalid_i = 1; dbus_rdata_i = 32'h1234;
        step();
        bus_idle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (wb_valid_o !== 1'b0 || exc_valid_o !== 1'b0) begin
                errors++; $display("FAIL late_rvalid got=wb%b exc%b exp=00",
                                   wb_valid_o, exc_valid_o);
            end
            step();
        end
    endtask

    task automatic test_clk_en();
        ex_valid_i = 1; ex_store_i = 0; ex_funct3_i = 3'b001;
        ex_addr_i = 32'h5002; ex_rd_i = 5'd7;
        step();
        ex_valid_i = 0; clk_en_i = 0; dbus_ack_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dbus_req_o !== 1'b1 || ex_ready_o !== 1'b0) begin
                errors++; $display("FAIL en_hold_req got=req%b rdy%b exp=req1 rdy0",
                                   dbus_req_o, ex_ready_o);
            end
        end
        clk_en_i = 1;
        step();
        dbus_ack_i = 0; clk_en_i = 0;
        dbus_rvalid_i = 1; dbus_rdata_i = 32'h8001_0000;
        step(); step();
        checks++;
        if (dbus_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin
            errors++; $display("FAIL en_hold_resp got=req%b wb%b exp=req0 wb0",
                               dbus_req_o, wb_valid_o);
        end
        clk_en_i = 1;
        step();
        bus_idle(); clk_en_i = 0;
        checks++;
        if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hFFFF8001) begin
            errors++; $display("FAIL en_wb got=%b %h exp=1 ffff8001",
                               wb_valid_o, wb_data_o);
        end
        step();
        checks++;
        if (wb_valid_o !== 1'b1) begin
            errors++; $display("FAIL en_wb_hold got=%b exp=1", wb_valid_o);
        end
        clk_en_i = 1;
        step();
        checks++;
        if (wb_valid_o !== 1'b0) begin
            errors++; $display("FAIL en_wb_clear got=%b exp=0", wb_valid_o);
        end
    endtask

    task automatic test_random();
        bit st, err, junk;
        logic [2:0] f3;
        logic [31:0] a, wd, rdat;
        logic [4:0] rd;
        logic [3:0] ec;
        int ad, rv, exp_rdy;
        for (int n = 0; n < 150; n++) begin
            st = 1'($urandom); err = ($urandom_range(0, 7) == 0);
            junk = 1'($urandom);
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
            else if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            a = $urandom; wd = $urandom; rdat = $urandom; rd = 5'($urandom);
            ad = $urandom_range(0, 3); rv = $urandom_range(0, 3);
            run_op(st, f3, a, wd, rd, ad, rv, rdat, err, junk);
            ec = m_cause(st, f3, a);
            checks++;
            if (o_both || o_extra || o_req_after) begin
                errors++; $display("FAIL rnd_pulse op%0d both%0d extra%0d req%0d exp=000",
                                   n, o_both, o_extra, o_req_after);
            end
            if (ec != 0) begin
                checks++;
                if (o_exc_t !== 1 || o_cause !== ec || o_exc_addr !== a ||
                    o_ready_t !== 1 || o_wb_t !== -1) begin
                    errors++; $display("FAIL rnd_exc op%0d got=t%0d c%0d %h rdy%0d exp=t1 c%0d %h rdy1",
                                       n, o_exc_t, o_cause, o_exc_addr, o_ready_t, ec, a);
                end
                continue;
            end
            checks++;
            if (o_addr !== {a[31:2], 2'b00} || o_be !== m_be(f3, a) ||
                o_we !== st || (st && o_wdata !== m_wdata(f3, wd)) || o_unstable) begin
                errors++; $display("FAIL rnd_bus op%0d got=%h/%b/%b/%h unst%0d exp=%h/%b/%b/%h",
                                   n, o_addr, o_be, o_we, o_wdata, o_unstable,
                                   {a[31:2], 2'b00}, m_be(f3, a), st, m_wdata(f3, wd));
            end
            exp_rdy = st ? ad + 2 : ad + rv + 3;
            checks++;
            if (o_ready_t !== exp_rdy) begin
                errors++; $display("FAIL rnd_ready op%0d got=%0d exp=%0d",
                                   n, o_ready_t, exp_rdy);
            end
            checks++;
            if (err) begin
                if (o_exc_t !== exp_rdy || o_cause !== (st ? 4'd7 : 4'd5) ||
                    o_exc_addr !== a || o_wb_t !== -1) begin
                    errors++; $display("FAIL rnd_fault op%0d got=t%0d c%0d %h wb%0d exp=t%0d c%0d %h",
                                       n, o_exc_t, o_cause, o_exc_addr, o_wb_t,
                                       exp_rdy, st ? 7 : 5, a);
                end
            end else if (st) begin
                if (o_wb_t !== -1 || o_exc_t !== -1) begin
                    errors++; $display("FAIL rnd_store op%0d got=wb%0d exc%0d exp=-1/-1",
                                       n, o_wb_t, o_exc_t);
                end
            end else if (o_wb_t !== exp_rdy || o_wb_data !== m_load(f3, a, rdat) ||
                         o_wb_rd !== rd || o_exc_t !== -1) begin
                errors++; $display("FAIL rnd_load op%0d got=t%0d %h rd%0d exp=t%0d %h rd%0d",
                                   n, o_wb_t, o_wb_data, o_wb_rd, exp_rdy,
                                   m_load(f3, a, rdat), rd);
            end
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int en_cnt, t;
        bit seen;
        run_op(1, 3'b010, 32'h6008, 32'h1, 5'd0, 1000, 0, 0, 0, 0);
        checks++;
        if (o_exc_t !== 5 || o_cause !== 4'd7 || o_exc_addr !== 32'h6008 ||
            o_ready_t !== 5 || o_req_after !== 1'b0) begin
            errors++; $display("FAIL to_store got=t%0d c%0d %h rdy%0d req%b exp=t5 c7 6008 rdy5 req0",
                               o_exc_t, o_cause, o_exc_addr, o_ready_t, o_req_after);
        end
        run_op(0, 3'b010, 32'h6010, 0, 5'd2, 0, 1000, 0, 0, 0);
        checks++;
        if (o_exc_t !== 6 || o_cause !== 4'd5 || o_wb_t !== -1) begin
            errors++; $display("FAIL to_load got=t%0d c%0d wb%0d exp=t6 c5 wb-1",
                               o_exc_t, o_cause, o_wb_t);
        end
        ex_valid_i = 1; ex_store_i = 1; ex_funct3_i = 3'b000; ex_addr_i = 32'h7001;
        step();
        ex_valid_i = 0; en_cnt = 0; seen = 0; t = 1;
        while (t < 40 && !seen) begin
            if (exc_valid_o) seen = 1;
            else begin
                clk_en_i = (t % 2 == 0);
                if (clk_en_i && dbus_req_o) en_cnt++;
                step();
                t++;
            end
        end
        clk_en_i = 1;
        checks++;
        if (!seen || en_cnt !== 4 || exc_cause_o !== 4'd7) begin
            errors++; $display("FAIL to_clk_en got=seen%0d cnt%0d c%0d exp=seen1 cnt4 c7",
                               seen, en_cnt, exc_cause_o);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_clk_en();
        test_random();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
